phase_sequencer: RTL

PHASE_SEQUENCER -- requirements
Module: phase_sequencer

---
 rtl/phase_sequencer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/phase_sequencer.sv
// Instruction-phase sequencer: reset hold, fetch/decode/exec/mem/writeback
// stepping with a bounded memory-acknowledge wait and a retired-instruction count.
//
// state  | meaning
// RSTH   | datapath held in reset while the hold counter runs down
// FETCH  | instruction fetch, waiting for mem_ack
// DECODE | one-cycle decode enable
// EXEC   | one-cycle execute enable, branches on is_mem
// MEM    | data access, waiting for mem_ack
// WB     | one-cycle writeback, retires the instruction
// HALT   | idle until rstreq or rst
module phase_sequencer #(
    parameter int RST_HOLD = 4,
    parameter int WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rstreq,
    input  logic        halt,
    input  logic        is_mem,
    input  logic        mem_ack,
    output logic        cpu_rst,
    output logic        fetch_en,
    output logic        decode_en,
    output logic        exec_en,
    output logic        wb_en,
    output logic        mem_req,
    output logic [2:0]  phase,
    output logic        timeout_err,
    output logic [31:0] instr_cnt
);

    localparam int HW = (RST_HOLD > 2) ? $clog2(RST_HOLD) : 1;
    localparam int WW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;
    localparam logic [HW-1:0] HOLD_INIT = HW'(RST_HOLD - 1);
    localparam logic [WW-1:0] WAIT_LIM  = WW'(WAIT_MAX);

    typedef enum logic [2:0] {
        RSTH   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6
    } state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          timeout_err_q, timeout_err_d;
    logic [31:0]   instr_cnt_q, instr_cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= RSTH;
            hold_q        <= HOLD_INIT;
            wait_q        <= '0;
            timeout_err_q <= 1'b0;
            instr_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            wait_q        <= wait_d;
            timeout_err_q <= timeout_err_d;
            instr_cnt_q   <= instr_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        hold_d        = hold_q;
        wait_d        = wait_q;
        timeout_err_d = timeout_err_q;
        instr_cnt_d   = instr_cnt_q;
        cpu_rst       = 1'b0;
        fetch_en      = 1'b0;
        decode_en     = 1'b0;
        exec_en       = 1'b0;
        wb_en         = 1'b0;
        mem_req       = 1'b0;
        phase         = state_q;

        case (state_q)
            RSTH: begin
                cpu_rst = 1'b1;
                if (hold_q == '0) begin
                    state_d = FETCH;
                    wait_d  = '0;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            FETCH: begin
                mem_req  = 1'b1;
                fetch_en = 1'b1;
                // a late ack on the limit cycle still wins over the timeout
                if (mem_ack) begin
                    state_d = DECODE;
                end else if (wait_q == WAIT_LIM) begin
                    timeout_err_d = 1'b1;
                    state_d       = HALT;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            DECODE: begin
                decode_en = 1'b1;
                state_d   = EXEC;
            end
            EXEC: begin
                exec_en = 1'b1;
                if (is_mem) begin
                    state_d = MEM;
                    wait_d  = '0;
                end else begin
                    state_d = WB;
                end
            end
            MEM: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    state_d = WB;
                end else if (wait_q == WAIT_LIM) begin
                    timeout_err_d = 1'b1;
                    state_d       = HALT;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            WB: begin
                wb_en       = 1'b1;
                instr_cnt_d = instr_cnt_q + 32'd1;
                if (halt) begin
                    state_d = HALT;
                end else begin
                    state_d = FETCH;
                    wait_d  = '0;
                end
            end
            HALT: begin
            end
            default: begin
                cpu_rst = 1'b1;
                phase   = 3'd0;
                state_d = RSTH;
                hold_d  = HOLD_INIT;
            end
        endcase

        // soft reset overrides every other transition, but keeps the count
        if (rstreq) begin
            state_d       = RSTH;
            hold_d        = HOLD_INIT;
            wait_d        = '0;
            timeout_err_d = 1'b0;
        end
    end

    assign timeout_err = timeout_err_q;
    assign instr_cnt   = instr_cnt_q;

endmodule
